// File: rtl/imem_loader.sv
// Byte-stream to 4-bank instruction memory loader.
// Gathers four bytes LSB-first and writes one word per bank strobe.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata_b0,
    output logic [7:0]        mem_wdata_b1,
    output logic [7:0]        mem_wdata_b2,
    output logic [7:0]        mem_wdata_b3,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        state;
    logic [1:0]        byte_idx;
    logic [ADDR_W:0]   word_idx;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W-1:0] base_q;
    logic [7:0]        lane0;
    logic [7:0]        lane1;
    logic [7:0]        lane2;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wd0;
    logic [7:0]        wd1;
    logic [7:0]        wd2;
    logic [7:0]        wd3;
    logic              err_q;

    logic              xfer;
    logic              bad_cnt;
    logic [ADDR_W:0]   next_idx;

    assign xfer     = in_valid && (state == S_COLLECT);
    assign bad_cnt  = (word_count == '0) || (word_count > MAX_CNT);
    assign next_idx = word_idx + 1'b1;

    assign in_ready     = (state == S_COLLECT);
    assign mem_we       = (state == S_WRITE) && !abort;
    assign busy         = (state == S_COLLECT) || (state == S_WRITE);
    assign done         = (state == S_DONE);
    assign error        = err_q;
    assign mem_addr     = addr_q;
    assign mem_wdata_b0 = wd0;
    assign mem_wdata_b1 = wd1;
    assign mem_wdata_b2 = wd2;
    assign mem_wdata_b3 = wd3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            byte_idx <= '0;
            word_idx <= '0;
            count_q  <= '0;
            base_q   <= '0;
            lane0    <= '0;
            lane1    <= '0;
            lane2    <= '0;
            addr_q   <= '0;
            wd0      <= '0;
            wd1      <= '0;
            wd2      <= '0;
            wd3      <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (bad_cnt) begin
                            err_q <= 1'b1;
                        end else begin
                            base_q   <= base_addr;
                            count_q  <= word_count;
                            byte_idx <= '0;
                            word_idx <= '0;
                            state    <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (abort) begin
                        state    <= S_IDLE;
                        err_q    <= 1'b1;
                        byte_idx <= '0;
                        lane0    <= '0;
                        lane1    <= '0;
                        lane2    <= '0;
                    end else if (xfer) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: lane0 <= in_data;
                            2'd1: lane1 <= in_data;
                            2'd2: lane2 <= in_data;
                            2'd3: begin
                                // Output regs only change on entry to WRITE
                                wd0    <= lane0;
                                wd1    <= lane1;
                                wd2    <= lane2;
                                wd3    <= in_data;
                                addr_q <= base_q + word_idx[ADDR_W-1:0];
                                state  <= S_WRITE;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        state    <= S_IDLE;
                        err_q    <= 1'b1;
                        byte_idx <= '0;
                    end else begin
                        word_idx <= next_idx;
                        state    <= (next_idx == count_q) ? S_DONE : S_COLLECT;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader.
// Expected writes come from a byte-list model of the load.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] word_count;
    logic       abort;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata_b0;
    logic [7:0] mem_wdata_b1;
    logic [7:0] mem_wdata_b2;
    logic [7:0] mem_wdata_b3;
    logic       busy;
    logic       done;
    logic       error;

    int checks = 0;
    int failures = 0;

    logic [39:0] wr_q[$];
    int done_cnt = 0;
    int err_cnt = 0;
    int rdy_cnt = 0;
    int rdy_in_wr = 0;

    imem_loader #(.ADDR_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr(base_addr),
        .word_count(word_count),
        .abort(abort),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata_b0(mem_wdata_b0),
        .mem_wdata_b1(mem_wdata_b1),
        .mem_wdata_b2(mem_wdata_b2),
        .mem_wdata_b3(mem_wdata_b3),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    // Bank-side observer: records every strobed write and pulse
    always @(negedge clk) begin
        if (mem_we)
            wr_q.push_back({mem_addr, mem_wdata_b3, mem_wdata_b2,
                            mem_wdata_b1, mem_wdata_b0});
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (in_ready) rdy_cnt++;
        if (in_ready && mem_we) rdy_in_wr++;
    end

    // Drives one load; reports words written, mismatches vs model,
    // done/error pulses and whether the bounds held.
    task automatic do_load(input logic [7:0] base, input int cnt,
                           input int mode, input bit directed,
                           output int nwr, output int nbad,
                           output int ndone, output int nerr,
                           output bit tmo);
        logic [7:0] bytes[$];
        logic [39:0] exp;
        int snap_w, snap_d, snap_e, idx, cyc, tog;
        bit v, x;
        bytes = {};
        for (int k = 0; k < cnt * 4; k++)
            bytes.push_back(directed ? 8'(8'h11 * (k + 1))
                                     : 8'($urandom));
        snap_w = wr_q.size();
        snap_d = done_cnt;
        snap_e = err_cnt;
        tmo = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        word_count = 9'(cnt);
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        cyc = 0;
        tog = 0;
        while (idx < cnt * 4 && cyc < cnt * 40 + 100) begin
            case (mode)
                0: v = 1'b1;
                1: v = (tog % 2) == 0;
                default: v = ($urandom % 2) == 1;
            endcase
            tog++;
            in_valid = v;
            in_data = bytes[idx];
            x = v && in_ready;
            @(posedge clk); #1;
            if (x) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        if (idx < cnt * 4) tmo = 1'b1;
        cyc = 0;
        while (busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (busy) tmo = 1'b1;
        repeat (3) @(negedge clk);
        nwr = wr_q.size() - snap_w;
        nbad = 0;
        for (int i = 0; i < cnt; i++) begin
            exp = {8'(base + 8'(i)), bytes[4*i+3], bytes[4*i+2],
                   bytes[4*i+1], bytes[4*i]};
            if (i >= nwr || wr_q[snap_w + i] !== exp) nbad++;
        end
        ndone = done_cnt - snap_d;
        nerr = err_cnt - snap_e;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        abort = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, mem_we, busy, done, error} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=00000",
                     {in_ready, mem_we, busy, done, error});
        end
        checks++;
        if ({mem_addr, mem_wdata_b3, mem_wdata_b2, mem_wdata_b1,
             mem_wdata_b0} !== 40'h0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0",
                     {mem_addr, mem_wdata_b3, mem_wdata_b2,
                      mem_wdata_b1, mem_wdata_b0});
        end
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int nwr, nbad, nd, ne;
        bit tmo;
        do_load(8'h10, 2, 0, 1'b1, nwr, nbad, nd, ne, tmo);
        checks++;
        if (nwr !== 2 || nbad !== 0) begin
            failures++;
            $display("FAIL basic_writes got=%0d bad=%0d want=2 bad=0",
                     nwr, nbad);
        end
        checks++;
        if (wr_q.size() < 2 || wr_q[wr_q.size()-2] !== 40'h10_44332211) begin
            failures++;
            $display("FAIL basic_word0 got=%h want=1044332211",
                     wr_q.size() >= 2 ? wr_q[wr_q.size()-2] : 40'h0);
        end
        checks++;
        if (nd !== 1 || ne !== 0 || busy !== 1'b0 || tmo) begin
            failures++;
            $display("FAIL basic_done got=d%0d e%0d b%b t%0d want=d1 e0 b0 t0",
                     nd, ne, busy, tmo);
        end
    endtask

    task automatic test_wrap();
        int nwr, nbad, nd, ne;
        bit tmo;
        do_load(8'hFF, 2, 0, 1'b0, nwr, nbad, nd, ne, tmo);
        checks++;
        if (nwr !== 2 || nbad !== 0 || ne !== 0 || nd !== 1 || tmo) begin
            failures++;
            $display("FAIL wrap got=w%0d bad%0d e%0d d%0d want=w2 bad0 e0 d1",
                     nwr, nbad, ne, nd);
        end
        checks++;
        if (wr_q.size() < 1 || wr_q[wr_q.size()-1][39:32] !== 8'h00) begin
            failures++;
            $display("FAIL wrap_addr got=%h want=00",
                     wr_q.size() >= 1 ? wr_q[wr_q.size()-1][39:32] : 8'hxx);
        end
    endtask

    task automatic test_bad_count();
        logic [8:0] bad[2];
        int sw, sr;
        bad[0] = 9'd0;
        bad[1] = 9'd257;
        for (int i = 0; i < 2; i++) begin
            sw = wr_q.size();
            sr = rdy_cnt;
            @(posedge clk); #1;
            start = 1'b1;
            word_count = bad[i];
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if (error !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL badcnt_err cnt=%0d got=e%b b%b want=e1 b0",
                         bad[i], error, busy);
            end
            repeat (4) @(negedge clk);
            checks++;
            if (error !== 1'b0 || wr_q.size() != sw || rdy_cnt != sr) begin
                failures++;
                $display("FAIL badcnt_quiet cnt=%0d got=e%b w%0d r%0d want=0",
                         bad[i], error, wr_q.size() - sw, rdy_cnt - sr);
            end
        end
    endtask

    task automatic test_abort();
        int sw, nwr, nbad, nd, ne;
        bit tmo;
        sw = wr_q.size();
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = 8'h40;
        word_count = 9'd3;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hA1;
        @(posedge clk); #1;
        in_data = 8'hA2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_state got=e%b b%b r%b want=e1 b0 r0",
                     error, busy, in_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_q.size() != sw || error !== 1'b0) begin
            failures++;
            $display("FAIL abort_nowrite got=w%0d e%b want=w0 e0",
                     wr_q.size() - sw, error);
        end
        do_load(8'h40, 1, 0, 1'b0, nwr, nbad, nd, ne, tmo);
        checks++;
        if (nwr !== 1 || nbad !== 0 || nd !== 1 || ne !== 0 || tmo) begin
            failures++;
            $display("FAIL abort_reload got=w%0d bad%0d d%0d e%0d want=w1 0 1 0",
                     nwr, nbad, nd, ne);
        end
    endtask

    task automatic test_toggle();
        int nwr, nbad, nd, ne, sv;
        bit tmo;
        sv = rdy_in_wr;
        do_load(8'($urandom), 3, 1, 1'b1, nwr, nbad, nd, ne, tmo);
        checks++;
        if (nwr !== 3 || nbad !== 0 || nd !== 1 || tmo) begin
            failures++;
            $display("FAIL toggle got=w%0d bad%0d d%0d want=w3 bad0 d1",
                     nwr, nbad, nd);
        end
        checks++;
        if (rdy_in_wr != sv) begin
            failures++;
            $display("FAIL toggle_ready_in_write got=%0d want=0",
                     rdy_in_wr - sv);
        end
    endtask

    task automatic test_random();
        int nwr, nbad, nd, ne, cnt, bad_runs;
        bit tmo;
        bad_runs = 0;
        for (int r = 0; r < 8; r++) begin
            cnt = $urandom_range(1, 6);
            do_load(8'($urandom), cnt, 2, 1'b0, nwr, nbad, nd, ne, tmo);
            if (nwr != cnt || nbad != 0 || nd != 1 || ne != 0 || tmo)
                bad_runs++;
        end
        checks++;
        if (bad_runs !== 0) begin
            failures++;
            $display("FAIL random_loads got=%0d bad runs want=0", bad_runs);
        end
    endtask

    task automatic test_max();
        int nwr, nbad, nd, ne;
        bit tmo;
        do_load(8'($urandom), 256, 0, 1'b0, nwr, nbad, nd, ne, tmo);
        checks++;
        if (nwr !== 256 || nbad !== 0 || nd !== 1 || ne !== 0 || tmo) begin
            failures++;
            $display("FAIL max_count got=w%0d bad%0d d%0d e%0d want=w256 0 1 0",
                     nwr, nbad, nd, ne);
        end
    endtask

    task automatic test_rst_mid();
        int sw, viol, nwr, nbad, nd, ne;
        bit tmo;
        sw = wr_q.size();
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = 8'h80;
        word_count = 9'd4;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h5A;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, mem_we, busy, done, error} !== 5'b0 ||
            {mem_addr, mem_wdata_b3, mem_wdata_b2, mem_wdata_b1,
             mem_wdata_b0} !== 40'h0) begin
            failures++;
            $display("FAIL rst_async got=%b/%h want=0",
                     {in_ready, mem_we, busy, done, error},
                     {mem_addr, mem_wdata_b3, mem_wdata_b2,
                      mem_wdata_b1, mem_wdata_b0});
        end
        start = 1'b1;
        word_count = 9'd1;
        viol = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy || in_ready || mem_we) viol++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (viol !== 0 || busy !== 1'b0 || wr_q.size() != sw) begin
            failures++;
            $display("FAIL rst_hold got=v%0d b%b w%0d want=0",
                     viol, busy, wr_q.size() - sw);
        end
        do_load(8'h22, 2, 2, 1'b0, nwr, nbad, nd, ne, tmo);
        checks++;
        if (nwr !== 2 || nbad !== 0 || nd !== 1 || ne !== 0 || tmo) begin
            failures++;
            $display("FAIL rst_reload got=w%0d bad%0d d%0d e%0d want=w2 0 1 0",
                     nwr, nbad, nd, ne);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_bad_count();
        test_abort();
        test_toggle();
        test_random();
        test_max();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
